// File: rtl/branch_resolve.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : branch_resolve
// Purpose  : Keeps the conditional branches that decode has predicted in
//            program order. When execute resolves the oldest one, this unit
//            drives the write port of the 2-bit-counter predictor. On a
//            misprediction it also sends a one-cycle redirect to fetch.
// Ports    : clk, rst_n (async, active low)
//            push/push_pc/push_pred        - enqueue a predicted branch
//            resolve/resolve_taken/target  - outcome of the oldest branch
//            flush                         - drop every in-flight entry
//            full/empty                    - FIFO status (from count)
//            w_addr/did_branch/we          - predictor update, 1 cycle
//            redirect/redirect_pc          - fetch restart, 1 cycle
//            overflow/underflow            - sticky error flags
//            stat_resolved/stat_mispred    - statistics counters
// Options  : BRES_STATS_EN - builds the saturating statistics counters.
//            When it is not defined, the stat ports are tied to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module branch_resolve #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [XLEN-1:0] push_pc,
   input  logic            push_pred,
   input  logic            resolve,
   input  logic            resolve_taken,
   input  logic [XLEN-1:0] resolve_target,
   input  logic            flush,
   output logic            full,
   output logic            empty,
   output logic [7:0]      w_addr,
   output logic            did_branch,
   output logic            we,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            overflow,
   output logic            underflow,
   output logic [31:0]     stat_resolved,
   output logic [31:0]     stat_mispred
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [XLEN-1:0]  entry_pc_q   [DEPTH];
   logic [XLEN-1:0]  entry_pc_d   [DEPTH];
   logic             entry_pred_q [DEPTH];
   logic             entry_pred_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             we_q, we_d;
   logic [7:0]       w_addr_q, w_addr_d;
   logic             did_branch_q, did_branch_d;
   logic             redirect_q, redirect_d;
   logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic [XLEN-1:0]  head_pc;
   logic             head_pred;
   logic             do_resolve;
   logic             mispred;
   logic             clear_all;
   logic             push_ok;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   always_comb begin
      head_pc    = entry_pc_q[rd_ptr_q];
      head_pred  = entry_pred_q[rd_ptr_q];
      do_resolve = resolve && !empty;
      mispred    = do_resolve && (head_pred != resolve_taken);
      clear_all  = flush || mispred;
      // When the FIFO is full, a resolve in the same cycle frees the head slot.
      // The tail then equals the head, and the head is read before the edge.
      push_ok    = push && (!full || do_resolve);

      entry_pc_d    = entry_pc_q;
      entry_pred_d  = entry_pred_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      we_d          = do_resolve;
      w_addr_d      = w_addr_q;
      did_branch_d  = did_branch_q;
      redirect_d    = mispred;
      redirect_pc_d = redirect_pc_q;
      overflow_d    = overflow_q || (push && full && !resolve);
      underflow_d   = underflow_q || (resolve && empty);

      if (do_resolve) begin
         w_addr_d     = head_pc[7:0];
         did_branch_d = resolve_taken;
      end
      if (mispred) begin
         redirect_pc_d = head_pred ? (head_pc + XLEN'(4)) : resolve_target;
      end

      if (clear_all) begin
         // Everything younger than a mispredicted branch is wrong-path.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            entry_pc_d[wr_ptr_q]   = push_pc;
            entry_pred_d[wr_ptr_q] = push_pred;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
         end
         if (do_resolve) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(do_resolve);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_pc_q[i]   <= '0;
            entry_pred_q[i] <= 1'b0;
         end
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         we_q          <= 1'b0;
         w_addr_q      <= '0;
         did_branch_q  <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         entry_pc_q    <= entry_pc_d;
         entry_pred_q  <= entry_pred_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         we_q          <= we_d;
         w_addr_q      <= w_addr_d;
         did_branch_q  <= did_branch_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
      end
   end

   assign we          = we_q;
   assign w_addr      = w_addr_q;
   assign did_branch  = did_branch_q;
   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

`ifdef BRES_STATS_EN
   logic [31:0] stat_resolved_q, stat_resolved_d;
   logic [31:0] stat_mispred_q, stat_mispred_d;

   // Saturating counters, so that a long run never wraps back to a small value.
   always_comb begin
      stat_resolved_d = stat_resolved_q;
      stat_mispred_d  = stat_mispred_q;
      if (do_resolve && (stat_resolved_q != 32'hFFFF_FFFF)) begin
         stat_resolved_d = stat_resolved_q + 32'd1;
      end
      if (mispred && (stat_mispred_q != 32'hFFFF_FFFF)) begin
         stat_mispred_d = stat_mispred_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_resolved_q <= '0;
         stat_mispred_q  <= '0;
      end else begin
         stat_resolved_q <= stat_resolved_d;
         stat_mispred_q  <= stat_mispred_d;
      end
   end

   assign stat_resolved = stat_resolved_q;
   assign stat_mispred  = stat_mispred_q;
`else
   assign stat_resolved = 32'd0;
   assign stat_mispred  = 32'd0;
`endif

endmodule
`default_nettype wire
